// File: rtl/trigger_crossbar_matrix.sv
// trigger_crossbar_matrix
//   NUM_IN x NUM_OUT run-time trigger routing matrix. Every output picks any
//   synchronised input and applies level or edge (stretched pulse) shaping,
//   optional inversion, or is held off. Sticky activity flags record which
//   inputs have changed since firmware last cleared them.
module trigger_crossbar_matrix #(
  parameter int NUM_IN       = 12,
  parameter int NUM_OUT      = 12,
  parameter int STRETCH_BITS = 8,
  parameter int SYNC_STAGES  = 2,
  localparam int CH_W        = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
  localparam int SRC_W       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       trig_in,
  input  logic                    cfg_wr_en,
  input  logic [CH_W-1:0]         cfg_channel,
  input  logic [SRC_W-1:0]        cfg_source,
  input  logic [1:0]              cfg_mode,
  input  logic                    cfg_invert,
  input  logic [STRETCH_BITS-1:0] cfg_stretch,
  output logic                    cfg_ack,
  output logic                    cfg_err,
  input  logic                    seen_clear,
  output logic [NUM_IN-1:0]       trig_seen,
  output logic [NUM_OUT-1:0]      trig_out
);

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'd0,
    MODE_RISE  = 2'd1,
    MODE_FALL  = 2'd2,
    MODE_OFF   = 2'd3
  } mode_e;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [NUM_IN-1:0]       sync_q [SYNC_STAGES];
  logic [NUM_IN-1:0]       hist_q;
  logic [NUM_IN-1:0]       sync_now;

  logic [SRC_W-1:0]        src_q     [NUM_OUT];
  mode_e                   mode_q    [NUM_OUT];
  logic                    inv_q     [NUM_OUT];
  logic [STRETCH_BITS-1:0] stretch_q [NUM_OUT];
  logic [STRETCH_BITS-1:0] cnt_q     [NUM_OUT];

  logic [STRETCH_BITS-1:0] cnt_d     [NUM_OUT];
  logic [NUM_OUT-1:0]      out_d;
  logic [NUM_OUT-1:0]      wr_hit;

  logic                    ch_ok;
  logic                    src_ok;
  logic                    cfg_valid;

  assign sync_now  = sync_q[SYNC_STAGES-1];

  // A write is only applied when both indices address real hardware.
  assign ch_ok     = (32'(cfg_channel) < 32'(NUM_OUT));
  assign src_ok    = (32'(cfg_source)  < 32'(NUM_IN));
  assign cfg_valid = ch_ok && src_ok;

  // ---------------------------------------------------------------------------
  // Input synchroniser chain plus one history stage for edge detection
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments so every flop in the
  // chain samples the value from before this edge, giving a true shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= trig_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_now;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky activity flags; a new change wins over a simultaneous clear
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_seen <= '0;
    end else begin
      trig_seen <= (trig_seen & {NUM_IN{~seen_clear}}) | (sync_now ^ hist_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-output configuration registers and write handshake
  // ---------------------------------------------------------------------------
  // NOTE: the configuration arrays are reset explicitly because the identity
  // routing map must be in place straight out of reset; these are small
  // register banks, not RAM, so a full reset is cheap and intended.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_OUT; o++) begin
        src_q[o]     <= SRC_W'(o % NUM_IN);
        mode_q[o]    <= MODE_LEVEL;
        inv_q[o]     <= 1'b0;
        stretch_q[o] <= '0;
      end
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      for (int o = 0; o < NUM_OUT; o++) begin
        if (wr_hit[o]) begin
          src_q[o]     <= cfg_source;
          mode_q[o]    <= mode_e'(cfg_mode);
          inv_q[o]     <= cfg_invert;
          stretch_q[o] <= cfg_stretch;
        end
      end
      cfg_ack <= cfg_wr_en;
      cfg_err <= cfg_wr_en && !cfg_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Routing, edge detection, pulse stretching and output shaping
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default at the top of the block so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    out_d  = '0;
    wr_hit = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      logic cur;
      logic old;
      logic edge_det;
      logic pulse;

      cnt_d[o] = cnt_q[o];
      cur      = sync_now[src_q[o]];
      old      = hist_q[src_q[o]];
      edge_det = 1'b0;
      pulse    = 1'b0;

      wr_hit[o] = cfg_wr_en && cfg_valid && (32'(cfg_channel) == 32'(o));

      unique case (mode_q[o])
        MODE_RISE: edge_det = cur & ~old;
        MODE_FALL: edge_det = ~cur & old;
        default:   edge_det = 1'b0;
      endcase

      // Retriggerable: an edge always reloads; otherwise count down to zero.
      if (edge_det) begin
        cnt_d[o] = stretch_q[o];
        pulse    = 1'b1;
      end else if (cnt_q[o] != '0) begin
        cnt_d[o] = cnt_q[o] - STRETCH_BITS'(1);
        pulse    = 1'b1;
      end else begin
        cnt_d[o] = '0;
        pulse    = 1'b0;
      end

      // Reconfiguring a channel aborts whatever pulse it was producing.
      if (wr_hit[o]) begin
        cnt_d[o] = '0;
        pulse    = 1'b0;
      end

      unique case (mode_q[o])
        MODE_LEVEL: out_d[o] = cur ^ inv_q[o];
        MODE_RISE,
        MODE_FALL:  out_d[o] = pulse ^ inv_q[o];
        default:    out_d[o] = 1'b0;
      endcase
    end
  end

  // Register stretch counters and the shaped outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_OUT; o++) cnt_q[o] <= '0;
      trig_out <= '0;
    end else begin
      for (int o = 0; o < NUM_OUT; o++) cnt_q[o] <= cnt_d[o];
      trig_out <= out_d;
    end
  end

endmodule
